// File: rtl/md_unit.sv
// md_unit: multiply/divide unit holding HI/LO, with a registered Busy flag for the hazard controller.
// Build option MD_UNIT_MADD_EN adds the madd/maddu/msub/msubu accumulate operations.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        ReadHi,
  output logic        Busy,
  output logic [31:0] Out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_UNIT_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      stateReg, stateNext;
  logic [3:0]  cntReg, cntNext;
  logic        busyReg;
  logic [31:0] hiReg, loReg;
  logic [31:0] pHiReg, pLoReg;
  logic        pWriteReg;

  logic isMul, isDiv, isAcc, isLong;
  logic loadPend, commit, writeHi, writeLo;

  always_comb begin
    isMul = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
    isDiv = (MDOp == OP_DIV) || (MDOp == OP_DIVU);
`ifdef MD_UNIT_MADD_EN
    isAcc = (MDOp == OP_MADD) || (MDOp == OP_MADDU) ||
            (MDOp == OP_MSUB) || (MDOp == OP_MSUBU);
`else
    isAcc = 1'b0;
`endif
    isLong = isMul || isDiv || isAcc;
  end

  // Sign-extending to 64 bits makes the low 64 bits of an unsigned multiply the signed product.
  logic [63:0] prodS, prodU;
  assign prodS = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prodU = {32'd0, A} * {32'd0, B};

  // Divide on magnitudes, then restore signs; this also yields 0x80000000 for the overflow case.
  logic        divSigned;
  logic [31:0] dvdMag, dvsMag, dvsSafe, quoMag, remMag, quo, rem;
  always_comb begin
    divSigned = (MDOp == OP_DIV);
    dvdMag    = (divSigned && A[31]) ? (~A + 32'd1) : A;
    dvsMag    = (divSigned && B[31]) ? (~B + 32'd1) : B;
    dvsSafe   = (dvsMag == 32'd0) ? 32'd1 : dvsMag;
    quoMag    = dvdMag / dvsSafe;
    remMag    = dvdMag % dvsSafe;
    quo       = (divSigned && (A[31] ^ B[31])) ? (~quoMag + 32'd1) : quoMag;
    rem       = (divSigned && A[31]) ? (~remMag + 32'd1) : remMag;
  end

`ifdef MD_UNIT_MADD_EN
  logic [63:0] accBase, accSum;
  always_comb begin
    accBase = {hiReg, loReg};
    case (MDOp)
      OP_MADD:  accSum = accBase + prodS;
      OP_MADDU: accSum = accBase + prodU;
      OP_MSUB:  accSum = accBase - prodS;
      default:  accSum = accBase - prodU;
    endcase
  end
`endif

  logic [63:0] resNext;
  logic        resWrite;
  always_comb begin
    resNext  = {pHiReg, pLoReg};
    resWrite = 1'b1;
    case (MDOp)
      OP_MULT:  resNext = prodS;
      OP_MULTU: resNext = prodU;
      OP_DIV, OP_DIVU: begin
        resNext  = {rem, quo};
        resWrite = (B != 32'd0);
      end
`ifdef MD_UNIT_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: resNext = accSum;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
      cntReg   <= 4'd0;
      busyReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      busyReg  <= (stateNext == RUN);
    end
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    case (stateReg)
      IDLE: begin
        if (Start && isLong) begin
          stateNext = RUN;
          cntNext   = isDiv ? DIV_CNT : MULT_CNT;
        end
      end
      RUN: begin
        cntNext = cntReg - 4'd1;
        if (cntReg == 4'd1) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Start is only honoured in IDLE; anything arriving during RUN is dropped.
  always_comb begin
    loadPend = (stateReg == IDLE) && Start && isLong;
    writeHi  = (stateReg == IDLE) && Start && (MDOp == OP_MTHI);
    writeLo  = (stateReg == IDLE) && Start && (MDOp == OP_MTLO);
    commit   = (stateReg == RUN) && (cntReg == 4'd1) && pWriteReg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hiReg     <= 32'd0;
      loReg     <= 32'd0;
      pHiReg    <= 32'd0;
      pLoReg    <= 32'd0;
      pWriteReg <= 1'b0;
    end else begin
      if (loadPend) begin
        pHiReg    <= resNext[63:32];
        pLoReg    <= resNext[31:0];
        pWriteReg <= resWrite;
      end
      if (commit) begin
        hiReg <= pHiReg;
        loReg <= pLoReg;
      end
      if (writeHi) hiReg <= A;
      if (writeLo) loReg <= A;
    end
  end

  assign Busy = busyReg;
  assign Out  = ReadHi ? hiReg : loReg;

endmodule
